// File: rtl/alu_seq.sv
// alu_seq: multi-cycle integer ALU for the core's execute stage.
// One operation per request/done handshake. Logic, arithmetic and compare ops
// finish in one cycle; shifts iterate one bit per cycle. Define ALU_MUL_EN to
// build the shift-add multiplier for opcode 10, otherwise that opcode is illegal.
module alu_seq #(
    parameter int REG_SIZE = 32,
    parameter int SHAMT_W  = $clog2(REG_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_req,
    input  logic [3:0]          alu_operation,
    input  logic [REG_SIZE-1:0] alu_op1,
    input  logic [REG_SIZE-1:0] alu_op2,
    output logic                alu_busy,
    output logic                alu_done,
    output logic [REG_SIZE-1:0] alu_res,
    output logic                alu_zero,
    output logic                alu_illegal
);

    // The counter must hold REG_SIZE for the multiplier, one bit wider than a shamt.
    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd10;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state_q;
    logic [3:0]          op_q;
    logic [REG_SIZE-1:0] val_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [REG_SIZE-1:0] res_q;
    logic                zero_q;
    logic                illegal_q;
`ifdef ALU_MUL_EN
    logic [REG_SIZE-1:0] mplr_q;
    logic [REG_SIZE-1:0] acc_q;
    logic [REG_SIZE-1:0] acc_d;
    logic                is_mul_d;
`endif

    logic [REG_SIZE-1:0] quick_d;
    logic [REG_SIZE-1:0] step_d;
    logic [SHAMT_W-1:0]  shamt_d;
    logic                is_quick_d;
    logic                is_shift_d;

    // Decode the incoming request and form every single-cycle result
    always_comb begin
        quick_d    = '0;
        is_quick_d = 1'b1;
        is_shift_d = 1'b0;
`ifdef ALU_MUL_EN
        is_mul_d   = 1'b0;
`endif
        shamt_d    = alu_op2[SHAMT_W-1:0];
        case (alu_operation)
            OP_ADD:  quick_d = alu_op1 + alu_op2;
            OP_SUB:  quick_d = alu_op1 - alu_op2;
            OP_AND:  quick_d = alu_op1 & alu_op2;
            OP_OR:   quick_d = alu_op1 | alu_op2;
            OP_XOR:  quick_d = alu_op1 ^ alu_op2;
            OP_SLT:  quick_d = {{(REG_SIZE-1){1'b0}}, ($signed(alu_op1) < $signed(alu_op2))};
            OP_SLTU: quick_d = {{(REG_SIZE-1){1'b0}}, (alu_op1 < alu_op2)};
            OP_SLL, OP_SRL, OP_SRA: begin
                is_quick_d = 1'b0;
                is_shift_d = 1'b1;
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                is_quick_d = 1'b0;
                is_mul_d   = 1'b1;
            end
`endif
            default: is_quick_d = 1'b0;
        endcase
    end

    // One iteration of the shifter (and the multiplier accumulate when built)
    always_comb begin
        case (op_q)
            OP_SLL:  step_d = val_q << 1;
            OP_SRL:  step_d = val_q >> 1;
            default: step_d = {val_q[REG_SIZE-1], val_q[REG_SIZE-1:1]};
        endcase
`ifdef ALU_MUL_EN
        acc_d = acc_q + (mplr_q[0] ? val_q : '0);
`endif
    end

    // Control FSM; outputs are registered so done/result change on one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            val_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
            mplr_q    <= '0;
            acc_q     <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (alu_req) begin
                        op_q  <= alu_operation;
                        val_q <= alu_op1;
                        cnt_q <= '0;
`ifdef ALU_MUL_EN
                        mplr_q <= alu_op2;
                        acc_q  <= '0;
`endif
                        if (is_quick_d) begin
                            res_q   <= quick_d;
                            zero_q  <= (quick_d == '0);
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (is_shift_d && (shamt_d == '0)) begin
                            res_q   <= alu_op1;
                            zero_q  <= (alu_op1 == '0);
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (is_shift_d) begin
                            cnt_q   <= {1'b0, shamt_d};
                            busy_q  <= 1'b1;
                            state_q <= S_BUSY;
                        end
`ifdef ALU_MUL_EN
                        else if (is_mul_d) begin
                            cnt_q   <= CNT_W'(REG_SIZE);
                            busy_q  <= 1'b1;
                            state_q <= S_BUSY;
                        end
`endif
                        else begin
                            res_q     <= '0;
                            zero_q    <= 1'b1;
                            illegal_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
`ifdef ALU_MUL_EN
                    if (op_q == OP_MUL) begin
                        val_q  <= val_q << 1;
                        mplr_q <= mplr_q >> 1;
                        acc_q  <= acc_d;
                        if (cnt_q == CNT_W'(1)) begin
                            res_q   <= acc_d;
                            zero_q  <= (acc_d == '0);
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else
`endif
                    begin
                        val_q <= step_d;
                        if (cnt_q == CNT_W'(1)) begin
                            res_q   <= step_d;
                            zero_q  <= (step_d == '0);
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_busy    = busy_q;
    assign alu_done    = done_q;
    assign alu_res     = res_q;
    assign alu_zero    = zero_q;
    assign alu_illegal = illegal_q;

endmodule
